// File: rtl/mdu_ctrl_pkg.sv
// Shared CPU definitions: decoder op codes, multiply/divide op encodings and latencies.
package mdu_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;

  localparam logic [3:0] MUL_CYC = 4'd5;
  localparam logic [3:0] DIV_CYC = 4'd10;

  function automatic logic md_valid(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

  // Multi-cycle ops: these occupy the unit and hold off MD instructions in D.
  function automatic logic md_is_long(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: HI/LO registers, fixed-latency mult/div, D-stage stall.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [63:0] r_res;
  logic        r_wr;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_long;
  logic        w_done;
  logic [31:0] w_b_safe;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quo_u;
  logic [31:0] w_rem_u;

  assign busy     = (r_state == S_BUSY);
  assign w_accept = start & ~busy & md_valid(mdop);
  assign w_long   = w_accept & md_is_long(mdop);
  assign w_done   = busy & (r_cnt == 4'd1);
  assign stall    = d_is_md & (busy | (start & md_is_long(mdop)));
  assign hi       = r_hi;
  assign lo       = r_lo;

  // Divisor forced non-zero so the operators never see 0; the result is discarded anyway.
  assign w_b_safe = (b == 32'd0) ? 32'd1 : b;
  assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_prod_u = {32'd0, a} * {32'd0, b};
  assign w_quo_s  = $signed(a) / $signed(w_b_safe);
  assign w_rem_s  = $signed(a) % $signed(w_b_safe);
  assign w_quo_u  = a / w_b_safe;
  assign w_rem_u  = a % w_b_safe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_long) w_state_nxt = S_BUSY;
      S_BUSY: if (w_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 4'd0;
      r_res <= 64'd0;
      r_wr  <= 1'b0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else if (w_accept) begin
      case (mdop)
        MD_MULT:  begin r_res <= w_prod_s; r_wr <= 1'b1; r_cnt <= MUL_CYC; end
        MD_MULTU: begin r_res <= w_prod_u; r_wr <= 1'b1; r_cnt <= MUL_CYC; end
        MD_DIV:   begin r_res <= {w_rem_s, w_quo_s}; r_wr <= (b != 32'd0); r_cnt <= DIV_CYC; end
        MD_DIVU:  begin r_res <= {w_rem_u, w_quo_u}; r_wr <= (b != 32'd0); r_cnt <= DIV_CYC; end
        MD_MTHI:  r_hi <= a;
        MD_MTLO:  r_lo <= a;
        default:  ;
      endcase
    end else if (busy) begin
      if (w_done) begin
        if (r_wr) {r_hi, r_lo} <= r_res;
        r_wr  <= 1'b0;
        r_cnt <= 4'd0;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed literal cases plus randomized traffic against a model.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mdop = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        d_is_md = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop), .a(a), .b(b),
    .d_is_md(d_is_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Model: a pending result commits on an absolute edge number.
  longint      edge_no = 0;
  bit          m_pend = 0;
  longint      m_commit = 0;
  bit          m_wr = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend = 0; m_hi = 0; m_lo = 0; m_wr = 0;
    end else begin
      edge_no++;
      if (m_pend && edge_no == m_commit) begin
        if (m_wr) begin m_hi = m_phi; m_lo = m_plo; end
        m_pend = 0;
      end else if (start && !m_pend && mdop >= 1 && mdop <= 6) begin
        case (mdop)
          1: begin {m_phi, m_plo} = longint'(signed'(a)) * longint'(signed'(b)); m_wr = 1; end
          2: begin {m_phi, m_plo} = {32'd0, a} * {32'd0, b}; m_wr = 1; end
          3: begin
               m_wr = (b != 0);
               if (m_wr) begin m_plo = signed'(a) / signed'(b); m_phi = signed'(a) % signed'(b); end
             end
          4: begin
               m_wr = (b != 0);
               if (m_wr) begin m_plo = a / b; m_phi = a % b; end
             end
          5: m_hi = a;
          default: m_lo = a;
        endcase
        if (mdop <= 2) begin m_pend = 1; m_commit = edge_no + 5; end
        else if (mdop <= 4) begin m_pend = 1; m_commit = edge_no + 10; end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("busy", {31'd0, busy}, {31'd0, m_pend});
    chk("stall", {31'd0, stall},
        {31'd0, d_is_md & (m_pend | (start & (mdop >= 1) & (mdop <= 4)))});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  // Issue one op for a single cycle, then count busy cycles seen at negedges.
  task automatic run_op(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                        output int ncyc);
    @(negedge clk);
    start = 1; mdop = op; a = va; b = vb;
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom;
    ncyc = 0;
    for (int i = 0; i < 30 && busy; i++) begin
      ncyc++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    #1 reset = 0;
    #2;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1;

    run_op(4'd1, 32'hFFFFFFFF, 32'h2, n);
    chk("mult_cyc", n, 5); chk("mult_hi", hi, 32'hFFFFFFFF); chk("mult_lo", lo, 32'hFFFFFFFE);
    run_op(4'd2, 32'hFFFFFFFF, 32'h2, n);
    chk("multu_cyc", n, 5); chk("multu_hi", hi, 32'h1); chk("multu_lo", lo, 32'hFFFFFFFE);
    run_op(4'd3, 32'hFFFFFFF9, 32'h2, n);
    chk("div_cyc", n, 10); chk("div_hi", hi, 32'hFFFFFFFF); chk("div_lo", lo, 32'hFFFFFFFD);
    run_op(4'd4, 32'd7, 32'd2, n);
    chk("divu_cyc", n, 10); chk("divu_hi", hi, 32'd1); chk("divu_lo", lo, 32'd3);

    run_op(4'd5, 32'h1234, 32'd0, n);
    chk("mthi_busy", n, 0); chk("mthi", hi, 32'h1234);
    run_op(4'd6, 32'h5678, 32'd0, n);
    chk("mtlo", lo, 32'h5678);
    run_op(4'd3, 32'd99, 32'd0, n);
    chk("div0_cyc", n, 10); chk("div0_hi", hi, 32'h1234); chk("div0_lo", lo, 32'h5678);

    // DIVU held on start while a MULT is in flight.
    @(negedge clk);
    start = 1; mdop = 4'd1; a = 32'd3; b = 32'd5; d_is_md = 1;
    #1 chk("stall_accept", {31'd0, stall}, 32'd1);
    @(negedge clk);
    mdop = 4'd4; a = 32'd100; b = 32'd7;
    n = 0;
    for (int i = 0; i < 30 && busy; i++) begin
      n++;
      chk("stall_busy", {31'd0, stall}, 32'd1);
      @(negedge clk);
    end
    chk("retry_mult_cyc", n, 5);
    chk("retry_mult_hi", hi, 32'd0); chk("retry_mult_lo", lo, 32'd15);
    @(negedge clk);
    start = 0; d_is_md = 0;
    n = 0;
    for (int i = 0; i < 30 && busy; i++) begin n++; @(negedge clk); end
    chk("retry_divu_cyc", n, 10);
    chk("retry_divu_hi", hi, 32'd2); chk("retry_divu_lo", lo, 32'd14);

    // Reset in the third busy cycle of a MULT.
    @(negedge clk);
    start = 1; mdop = 4'd1; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 0;
    #1;
    chk("mid_rst_hi", hi, 32'd0); chk("mid_rst_lo", lo, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1;
    repeat (10) @(negedge clk);
    chk("post_rst_hi", hi, 32'd0); chk("post_rst_lo", lo, 32'd0);

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 3) != 0);
      mdop    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      a       = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(0, 20)) - 32'd10;
        default: b = $urandom;
      endcase
      if (mdop == 4'd3 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      d_is_md = $urandom_range(0, 1);
      if ($urandom_range(0, 400) == 0) begin
        reset = 0; #2; reset = 1;
      end
    end
    @(negedge clk);
    start = 0;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
